fetch_stage: RTL and testbench

Instruction fetch stage with IF/ID pipeline register, directly upstream of main_decoder. It holds the PC and issues single-outstanding requests to instruction memory. It buffers the returned word and presents instr/pc to the decode stage; instr[6:0] drives main_decoder op. It honours load-use stall from the hazard unit and branch/jal redirect from EX.

---
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch, skid buffer and IF/ID register.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect halts fetch and sets sticky fetch_misalign.
module fetch_stage #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic            fetch_misalign
);
   typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
   state_t state, state_nx;
   logic [XLEN-1:0] pc, pc_nx, skid_instr, skid_pc, rpc;
   logic drop, drop_nx, misalign, gnt_ok, rsp, take, load_new, from_skid;
`ifdef FETCH_MISALIGN_CHK_EN
   assign rpc = redirect_pc;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) misalign <= 1'b0;
      else if (redirect) misalign <= |redirect_pc[1:0];
`else
   assign rpc = redirect_pc & ~XLEN'(3);
   assign misalign = 1'b0;
`endif
   assign imem_req = rst_n && state == FETCH && !misalign;
   assign imem_addr = pc;
   assign fetch_misalign = misalign;
   assign gnt_ok = imem_req && imem_gnt;
   assign rsp = state == WAIT && imem_rvalid;
   assign take = rsp && !drop && !redirect;
   assign load_new = take && (!stall || !if_id_valid);
   assign from_skid = state == HOLD && !stall && !redirect;
   // a grant or pending response to the old address must be swallowed after a redirect
   always_comb begin
      pc_nx = take ? pc + XLEN'(4) : pc;
      drop_nx = rsp ? 1'b0 : drop;
      state_nx = state == FETCH ? (gnt_ok ? WAIT : FETCH) :
                 state == WAIT  ? (!imem_rvalid ? WAIT : (drop || load_new) ? FETCH : HOLD) :
                 (stall ? HOLD : FETCH);
      if (redirect) begin
         pc_nx = rpc;
         drop_nx = (state == FETCH && gnt_ok) || (state == WAIT && !imem_rvalid);
         state_nx = drop_nx ? WAIT : FETCH;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= FETCH;
         pc <= RESET_PC;
         drop <= 1'b0;
         skid_instr <= '0;
         skid_pc <= '0;
         if_id_valid <= 1'b0;
         if_id_instr <= XLEN'(32'h0000_0013);
         if_id_pc <= '0;
         if_id_pc_plus4 <= '0;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
         drop <= drop_nx;
         if (take && !load_new) begin
            skid_instr <= imem_rdata;
            skid_pc <= pc;
         end
         if (redirect) if_id_valid <= 1'b0;
         else if (load_new) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc <= pc;
            if_id_pc_plus4 <= pc + XLEN'(4);
         end else if (from_skid) begin
            if_id_valid <= 1'b1;
            if_id_instr <= skid_instr;
            if_id_pc <= skid_pc;
            if_id_pc_plus4 <= skid_pc + XLEN'(4);
         end else if (!stall) if_id_valid <= 1'b0;
      end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a random run checked against an in-order program-flow model.
module tb_fetch_stage;
   logic clk = 1'b0, rst_n = 1'b0;
   logic imem_req, imem_gnt, imem_rvalid, stall, redirect, if_id_valid, fetch_misalign;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, if_id_instr, if_id_pc, if_id_pc_plus4;
   int total = 0, bad = 0, viol = 0, cnt = 0, lat = 1;
   bit pend = 0, seen;
   logic [31:0] paddr = '0;

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4), .fetch_misalign(fetch_misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h0010_0113 : (a ^ 32'h5A5A_0000) | 32'h3;
   endfunction

   // one clock of the memory model: rvalid `lat` cycles after a grant
   task automatic cyc();
      logic fr;
      logic [31:0] fa;
      imem_rvalid = pend && cnt == 0;
      imem_rdata = imem_rvalid ? memf(paddr) : 32'h0;
      fr = imem_req && imem_gnt;
      fa = imem_addr;
      if (fr && (pend || fa[1:0] != 2'b00)) viol++;
      @(posedge clk); #1;
      if (imem_rvalid) pend = 0;
      else if (pend) cnt--;
      if (fr) begin pend = 1; cnt = lat - 1; paddr = fa; end
   endtask

   task automatic test_reset();
      rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; pend = 0; lat = 1;
      repeat (2) cyc();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", imem_req); end
      total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
      total++; if (if_id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got %h want 00000013", if_id_instr); end
      total++; if (if_id_pc !== 0 || if_id_pc_plus4 !== 0) begin bad++; $display("FAIL rst_pc got %h/%h want 0/0", if_id_pc, if_id_pc_plus4); end
      total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got %b want 0", fetch_misalign); end
      rst_n = 1; #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rel_req got %b@%h want 1@0", imem_req, imem_addr); end
   endtask

   task automatic test_basic();
      imem_gnt = 1; lat = 1;
      repeat (2) cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0050_0093 || if_id_pc_plus4 !== 32'h4)
         begin bad++; $display("FAIL basic0 got %b %h %h %h want 1 0 00500093 4", if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4); end
      total++; if (imem_req !== 1 || imem_addr !== 32'h4) begin bad++; $display("FAIL basic_addr got %b@%h want 1@4", imem_req, imem_addr); end
      cyc();
      total++; if (if_id_valid !== 0) begin bad++; $display("FAIL basic_bubble got %b want 0", if_id_valid); end
      cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'h4 || if_id_instr !== 32'h0010_0113 || if_id_pc_plus4 !== 32'h8)
         begin bad++; $display("FAIL basic1 got %b %h %h %h want 1 4 00100113 8", if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4); end
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (i == 2) stall = 0;
         total++; if (imem_req !== 0 || if_id_pc !== 32'h4 || if_id_instr !== 32'h0010_0113)
            begin bad++; $display("FAIL stall_hold%0d got req=%b pc=%h instr=%h want 0 4 00100113", i, imem_req, if_id_pc, if_id_instr); end
      end
      cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'h8 || if_id_instr !== memf(32'h8) || if_id_pc_plus4 !== 32'hC)
         begin bad++; $display("FAIL stall_skid got %b %h %h %h want 1 8 %h c", if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4, memf(32'h8)); end
      total++; if (imem_req !== 1 || imem_addr !== 32'hC) begin bad++; $display("FAIL stall_next got %b@%h want 1@c", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      lat = 3;
      cyc();
      redirect = 1; redirect_pc = 32'h40;
      cyc();
      redirect = 0; lat = 1; seen = 0;
      total++; if (if_id_valid !== 0) begin bad++; $display("FAIL rdw_kill got %b want 0", if_id_valid); end
      for (int i = 0; i < 20 && !if_id_valid; i++) begin
         if (imem_req && !seen) begin
            seen = 1;
            total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL rdw_addr got %h want 40", imem_addr); end
         end
         cyc();
      end
      total++; if (!seen || if_id_valid !== 1 || if_id_pc !== 32'h40 || if_id_instr !== memf(32'h40))
         begin bad++; $display("FAIL rdw_first got seen=%b %b %h %h want 1 1 40 %h", seen, if_id_valid, if_id_pc, if_id_instr, memf(32'h40)); end
   endtask

   task automatic test_redirect_rvalid();
      stall = 1; lat = 1;
      cyc();
      redirect = 1; redirect_pc = 32'h80;
      cyc();
      redirect = 0; stall = 0;
      total++; if (if_id_valid !== 0 || imem_req !== 1 || imem_addr !== 32'h80)
         begin bad++; $display("FAIL rdr got valid=%b req=%b@%h want 0 1@80", if_id_valid, imem_req, imem_addr); end
      for (int i = 0; i < 20 && !if_id_valid; i++) cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'h80 || if_id_instr !== memf(32'h80))
         begin bad++; $display("FAIL rdr_first got %b %h %h want 1 80 %h", if_id_valid, if_id_pc, if_id_instr, memf(32'h80)); end
   endtask

   task automatic test_wrap();
      imem_gnt = 0; redirect = 1; redirect_pc = 32'hFFFF_FFFC;
      cyc();
      redirect = 0; imem_gnt = 1;
      for (int i = 0; i < 20 && !if_id_valid; i++) cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0)
         begin bad++; $display("FAIL wrap_top got %b %h %h want 1 fffffffc 0", if_id_valid, if_id_pc, if_id_pc_plus4); end
      cyc();
      for (int i = 0; i < 20 && !if_id_valid; i++) cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0050_0093)
         begin bad++; $display("FAIL wrap_zero got %b %h %h want 1 0 00500093", if_id_valid, if_id_pc, if_id_instr); end
   endtask

   task automatic test_reset_mid();
      lat = 3;
      cyc();
      #2 rst_n = 0; #1;
      total++; if (imem_req !== 0 || if_id_valid !== 0 || if_id_instr !== 32'h13 || if_id_pc !== 0 || if_id_pc_plus4 !== 0)
         begin bad++; $display("FAIL rmid_async got req=%b %b %h %h %h want 0 0 13 0 0", imem_req, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4); end
      repeat (4) cyc();
      rst_n = 1; lat = 1; #1;
      total++; if (imem_req !== 1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rmid_req got %b@%h want 1@0", imem_req, imem_addr); end
      for (int i = 0; i < 20 && !if_id_valid; i++) cyc();
      total++; if (if_id_valid !== 1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0050_0093)
         begin bad++; $display("FAIL rmid_first got %b %h %h want 1 0 00500093", if_id_valid, if_id_pc, if_id_instr); end
   endtask

   task automatic test_misalign();
      int reqs = 0;
      imem_gnt = 0; redirect = 1; redirect_pc = 32'h42;
      cyc();
      redirect = 0;
`ifdef FETCH_MISALIGN_CHK_EN
      total++; if (fetch_misalign !== 1 || imem_req !== 0) begin bad++; $display("FAIL mis_set got %b req=%b want 1 0", fetch_misalign, imem_req); end
      imem_gnt = 1;
      for (int i = 0; i < 5; i++) begin reqs += int'(imem_req); cyc(); end
      total++; if (reqs !== 0 || fetch_misalign !== 1) begin bad++; $display("FAIL mis_halt got reqs=%0d flag=%b want 0 1", reqs, fetch_misalign); end
      imem_gnt = 0; redirect = 1; redirect_pc = 32'h80;
      cyc();
      redirect = 0; imem_gnt = 1;
      total++; if (fetch_misalign !== 0 || imem_req !== 1 || imem_addr !== 32'h80)
         begin bad++; $display("FAIL mis_clear got %b req=%b@%h want 0 1@80", fetch_misalign, imem_req, imem_addr); end
`else
      total++; if (fetch_misalign !== 0 || imem_req !== 1 || imem_addr !== 32'h40)
         begin bad++; $display("FAIL mis_force got %b req=%b@%h want 0 1@40", fetch_misalign, imem_req, imem_addr); end
      imem_gnt = 1;
`endif
      for (int i = 0; i < 20 && !if_id_valid; i++) cyc();
      total++; if (if_id_valid !== 1 || if_id_pc[1:0] !== 2'b00 || if_id_instr !== memf(if_id_pc))
         begin bad++; $display("FAIL mis_fetch got %b %h %h", if_id_valid, if_id_pc, if_id_instr); end
   endtask

   // decode consumes IF/ID when valid, unstalled and not killed; it must see the program flow in order
   task automatic test_random();
      logic [31:0] exp_pc = 32'h0;
      int n = 0;
      rst_n = 0; stall = 0; redirect = 0;
      repeat (2) cyc();
      pend = 0; viol = 0; rst_n = 1;
      for (int i = 0; i < 3000; i++) begin
         stall = $urandom_range(0, 2) == 0;
         redirect = $urandom_range(0, 19) == 0;
         redirect_pc = $urandom & 32'h0000_FFFC;
         imem_gnt = $urandom_range(0, 2) != 0;
         lat = $urandom_range(1, 3);
         if (if_id_valid && !stall && !redirect) begin
            total++; if (if_id_pc !== exp_pc || if_id_instr !== memf(exp_pc) || if_id_pc_plus4 !== exp_pc + 32'd4)
               begin bad++; $display("FAIL rnd_flow got %h %h %h want %h %h %h", if_id_pc, if_id_instr, if_id_pc_plus4, exp_pc, memf(exp_pc), exp_pc + 32'd4); end
            exp_pc += 32'd4; n++;
         end
         if (redirect) exp_pc = redirect_pc;
         cyc();
      end
      redirect = 0; stall = 0;
      total++; if (viol !== 0) begin bad++; $display("FAIL rnd_protocol got %0d violations want 0", viol); end
      total++; if (n < 200) begin bad++; $display("FAIL rnd_progress got %0d instrs want >=200", n); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_redirect_rvalid();
      test_wrap();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
